mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_mux2.sv | 11 +
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// Supplies the data width when no Constants.vh definition is present.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } ArbState_t;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_TIMEOUT = 255;

    // Timeout counter is at least 8 bits wide and always able to hold TIMEOUT.
    function automatic int timeout_cnt_w(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave = arbiter, master = environment.
// Err0/Err1 exist only when ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W
);
    logic                    Req0;
    logic                    Req1;
    logic                    We0;
    logic                    We1;
    logic [ADDR_W-1:0]       Addr0;
    logic [ADDR_W-1:0]       Addr1;
    logic [`DATA_WIDTH-1:0]  WData0;
    logic [`DATA_WIDTH-1:0]  WData1;
    logic                    Done0;
    logic                    Done1;
    logic [`DATA_WIDTH-1:0]  RData;
    logic                    MemReq;
    logic                    MemWe;
    logic                    MemSel;
    logic [ADDR_W-1:0]       MemAddr;
    logic [`DATA_WIDTH-1:0]  MemWData;
    logic [`DATA_WIDTH-1:0]  MemRData;
    logic                    MemAck;
`ifdef ARB_TIMEOUT_EN
    logic                    Err0;
    logic                    Err1;
`endif

    modport slave (
`ifdef ARB_TIMEOUT_EN
        output Err0, Err1,
`endif
        input  Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
        input  MemRData, MemAck,
        output Done0, Done1, RData,
        output MemReq, MemWe, MemSel, MemAddr, MemWData
    );

    modport master (
`ifdef ARB_TIMEOUT_EN
        input  Err0, Err1,
`endif
        output Req0, Req1, We0, We1, Addr0, Addr1, WData0, WData1,
        output MemRData, MemAck,
        input  Done0, Done1, RData,
        input  MemReq, MemWe, MemSel, MemAddr, MemWData
    );

endinterface

// File: rtl/mem_port_arbiter_mux2.sv
// Two-input word multiplexer used to steer the owner's address and write data.
module Mux2 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between CPU (port 0) and loader/DMA (port 1).
// Optional busy timeout with Err0/Err1 abort pulses is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W
`ifdef ARB_TIMEOUT_EN
    , parameter int TIMEOUT = ARB_TIMEOUT
`endif
) (
    input  logic                Clk,
    input  logic                Rst_n,
    mem_port_arbiter_if.slave   bus
);

    ArbState_t               state_reg;
    logic                    last_gnt_reg;
    logic                    mem_sel_reg;
    logic                    mem_req_reg;
    logic [`DATA_WIDTH-1:0]  rdata_reg;
    logic [ADDR_W-1:0]       mem_addr;
    logic [`DATA_WIDTH-1:0]  mem_wdata;
    logic                    done0;
    logic                    done1;
    logic                    abort;

    assign done0 = (state_reg == BUSY0) && bus.MemAck;
    assign done1 = (state_reg == BUSY1) && bus.MemAck;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = timeout_cnt_w(TIMEOUT);
    logic [CNT_W-1:0] cnt_reg;

    // Counter value k-1 during the k-th busy cycle, so the abort lands on busy cycle TIMEOUT.
    assign abort = (state_reg != IDLE) && !bus.MemAck && (cnt_reg == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            cnt_reg <= '0;
        end else if (state_reg == IDLE) begin
            cnt_reg <= '0;
        end else if (!bus.MemAck) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign bus.Err0 = abort && (state_reg == BUSY0);
    assign bus.Err1 = abort && (state_reg == BUSY1);
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
            mem_sel_reg  <= 1'b0;
            mem_req_reg  <= 1'b0;
            rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // On a tie the port that did not win last time is granted.
                    if (bus.Req0 && (!bus.Req1 || last_gnt_reg)) begin
                        state_reg    <= BUSY0;
                        mem_sel_reg  <= 1'b0;
                        last_gnt_reg <= 1'b0;
                        mem_req_reg  <= 1'b1;
                    end else if (bus.Req1) begin
                        state_reg    <= BUSY1;
                        mem_sel_reg  <= 1'b1;
                        last_gnt_reg <= 1'b1;
                        mem_req_reg  <= 1'b1;
                    end
                end
                BUSY0, BUSY1: begin
                    if (bus.MemAck) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                        rdata_reg   <= bus.MemRData;
                    end else if (abort) begin
                        state_reg   <= IDLE;
                        mem_req_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    mem_req_reg <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (ADDR_W == `DATA_WIDTH) begin : g_addr_mux
            Mux2 #(.W(ADDR_W)) u_addr_mux (
                .d0  (bus.Addr0),
                .d1  (bus.Addr1),
                .sel (mem_sel_reg),
                .y   (mem_addr)
            );
        end else begin : g_addr_sel
            assign mem_addr = mem_sel_reg ? bus.Addr1 : bus.Addr0;
        end
    endgenerate

    Mux2 #(.W(`DATA_WIDTH)) u_wdata_mux (
        .d0  (bus.WData0),
        .d1  (bus.WData1),
        .sel (mem_sel_reg),
        .y   (mem_wdata)
    );

    assign bus.MemReq   = mem_req_reg;
    assign bus.MemSel   = mem_sel_reg;
    assign bus.MemAddr  = mem_addr;
    assign bus.MemWData = mem_wdata;
    assign bus.MemWe    = mem_req_reg && (mem_sel_reg ? bus.We1 : bus.We0);
    assign bus.Done0    = done0;
    assign bus.Done1    = done1;
    // Read data is live only on the ack cycle; otherwise the last captured word is held.
    assign bus.RData    = (done0 || done1) ? bus.MemRData : rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the timeout section runs only with ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    logic Clk;
    logic Rst_n;
    int   checks;
    int   failures;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

`ifdef ARB_TIMEOUT_EN
    mem_port_arbiter #(.ADDR_W(32), .TIMEOUT(8)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
`else
    mem_port_arbiter #(.ADDR_W(32)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));
`endif

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_wdata;
        int          exp_owner;

        checks = 0;
        failures = 0;
        Rst_n = 1'b0;
        bus.Req0 = 1'b1;   bus.Req1 = 1'b0;
        bus.We0 = 1'b0;    bus.We1 = 1'b0;
        bus.Addr0 = 32'h0000_0010; bus.Addr1 = 32'h0;
        bus.WData0 = 32'h0; bus.WData1 = 32'h0;
        bus.MemAck = 1'b0; bus.MemRData = 32'h0;

        // Reset held with Req0 asserted
        tick(); tick();
        check_value("rst_memreq", {31'b0, bus.MemReq}, 32'd0);
        check_value("rst_memsel", {31'b0, bus.MemSel}, 32'd0);
        check_value("rst_done", {30'b0, bus.Done1, bus.Done0}, 32'd0);
        check_value("rst_rdata", bus.RData, 32'h0);
        Rst_n = 1'b1;
        tick();
        check_value("first_memreq", {31'b0, bus.MemReq}, 32'd1);
        check_value("first_memsel", {31'b0, bus.MemSel}, 32'd0);
        check_value("first_addr", bus.MemAddr, 32'h0000_0010);

        // Port 0 read, ack three cycles after MemReq rises
        tick();
        check_value("p0_wait_done", {31'b0, bus.Done0}, 32'd0);
        tick();
        tick();
        bus.MemAck = 1'b1; bus.MemRData = 32'hDEAD_BEEF;
        #1;
        check_value("p0_done0", {31'b0, bus.Done0}, 32'd1);
        check_value("p0_done1", {31'b0, bus.Done1}, 32'd0);
        check_value("p0_rdata", bus.RData, 32'hDEAD_BEEF);
        $display("txn port=0 read rdata=0x%08h", bus.RData);
        bus.Req0 = 1'b0;
        tick();
        bus.MemAck = 1'b0; bus.MemRData = 32'h5555_AAAA;
        #1;
        check_value("p0_idle_memreq", {31'b0, bus.MemReq}, 32'd0);
        check_value("p0_done_gone", {31'b0, bus.Done0}, 32'd0);
        check_value("p0_rdata_hold", bus.RData, 32'hDEAD_BEEF);

        // MemAck in IDLE is ignored
        bus.MemAck = 1'b1;
        #1;
        check_value("idle_ack_done", {30'b0, bus.Done1, bus.Done0}, 32'd0);
        tick();
        bus.MemAck = 1'b0;
        check_value("idle_ack_memreq", {31'b0, bus.MemReq}, 32'd0);

        // Port 1 write
        bus.Req1 = 1'b1; bus.We1 = 1'b1;
        bus.Addr1 = 32'h40; bus.WData1 = 32'h1234_5678;
        tick();
        check_value("p1_memwe", {31'b0, bus.MemWe}, 32'd1);
        check_value("p1_memsel", {31'b0, bus.MemSel}, 32'd1);
        check_value("p1_addr", bus.MemAddr, 32'h40);
        check_value("p1_wdata", bus.MemWData, 32'h1234_5678);
        tick();
        check_value("p1_memwe_hold", {31'b0, bus.MemWe}, 32'd1);
        bus.MemAck = 1'b1;
        #1;
        check_value("p1_done1", {31'b0, bus.Done1}, 32'd1);
        check_value("p1_done0", {31'b0, bus.Done0}, 32'd0);
        $display("txn port=1 write addr=0x%08h wdata=0x%08h", bus.MemAddr, bus.MemWData);
        bus.Req1 = 1'b0; bus.We1 = 1'b0;
        tick();
        bus.MemAck = 1'b0;
        #1;
        check_value("p1_done1_once", {31'b0, bus.Done1}, 32'd0);
        check_value("p1_idle_memwe", {31'b0, bus.MemWe}, 32'd0);
        check_value("p1_idle_sel_hold", {31'b0, bus.MemSel}, 32'd1);

        // Both ports requesting continuously: strict alternation starting at port 0
        bus.Addr0 = 32'h100; bus.WData0 = 32'hA0A0_0000;
        bus.Addr1 = 32'h200; bus.WData1 = 32'hB1B1_0001;
        bus.Req0 = 1'b1; bus.Req1 = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_owner = i % 2;
            exp_wdata = (exp_owner == 0) ? 32'hA0A0_0000 : 32'hB1B1_0001;
            check_value($sformatf("rr%0d_bubble", i), {31'b0, bus.MemReq}, 32'd0);
            tick();
            check_value($sformatf("rr%0d_memreq", i), {31'b0, bus.MemReq}, 32'd1);
            check_value($sformatf("rr%0d_owner", i), {31'b0, bus.MemSel}, exp_owner);
            check_value($sformatf("rr%0d_wdata", i), bus.MemWData, exp_wdata);
            tick();
            bus.MemAck = 1'b1; bus.MemRData = 32'h100 + i;
            #1;
            check_value($sformatf("rr%0d_done", i), {30'b0, bus.Done1, bus.Done0},
                        (exp_owner == 0) ? 32'd1 : 32'd2);
            $display("txn port=%0d rr read rdata=0x%08h", exp_owner, bus.RData);
            if (i == 5) begin
                bus.Req0 = 1'b0; bus.Req1 = 1'b0;
            end
            tick();
            bus.MemAck = 1'b0;
            #1;
        end

        // Reset two cycles into BUSY1 abandons the access
        bus.Req1 = 1'b1;
        tick();
        tick();
        Rst_n = 1'b0;
        #1;
        check_value("mid_rst_memreq", {31'b0, bus.MemReq}, 32'd0);
        check_value("mid_rst_done1", {31'b0, bus.Done1}, 32'd0);
        check_value("mid_rst_memsel", {31'b0, bus.MemSel}, 32'd0);
        tick();
        Rst_n = 1'b1;
        tick();
        check_value("post_rst_memreq", {31'b0, bus.MemReq}, 32'd1);
        check_value("post_rst_memsel", {31'b0, bus.MemSel}, 32'd1);
        bus.MemAck = 1'b1;
        #1;
        check_value("post_rst_done1", {31'b0, bus.Done1}, 32'd1);
        $display("txn port=1 after reset");
        bus.Req1 = 1'b0;
        tick();
        bus.MemAck = 1'b0;
        #1;

`ifdef ARB_TIMEOUT_EN
        // No ack: abort on the 8th busy cycle
        bus.Req0 = 1'b1;
        tick();
        for (int k = 1; k < 8; k++) begin
            check_value($sformatf("to_wait%0d_err0", k), {31'b0, bus.Err0}, 32'd0);
            tick();
        end
        check_value("to_err0", {31'b0, bus.Err0}, 32'd1);
        check_value("to_done0", {31'b0, bus.Done0}, 32'd0);
        $display("txn port=0 timeout");
        bus.Req0 = 1'b0;
        tick();
        check_value("to_idle_memreq", {31'b0, bus.MemReq}, 32'd0);
        check_value("to_err0_once", {31'b0, bus.Err0}, 32'd0);

        // Ack on the timeout cycle wins
        bus.Req0 = 1'b1;
        tick();
        for (int k = 1; k < 8; k++) tick();
        bus.MemAck = 1'b1;
        #1;
        check_value("to_ack_done0", {31'b0, bus.Done0}, 32'd1);
        check_value("to_ack_err0", {31'b0, bus.Err0}, 32'd0);
        $display("txn port=0 ack on timeout cycle");
        bus.Req0 = 1'b0;
        tick();
        bus.MemAck = 1'b0;
        #1;
        check_value("to_ack_idle", {31'b0, bus.MemReq}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
